// File: rtl/code_loader_if.sv
// +-------------------------------------------------------------------------+
// | code_loader_if : byte-stream input and code-memory write bus             |
// | Revision 1.0                                                             |
// +-------------------------------------------------------------------------+
`default_nettype none

interface code_loader_if #(
  parameter int CODE_DIR_WIDTH = 4
);
  logic                      byte_valid;
  logic [7:0]                byte_data;
  logic                      byte_ready;
  logic                      mem_we;
  logic [CODE_DIR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_wdata;

  // The loader consumes the stream and drives the memory bus.
  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  // Stream source / memory side.
  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/code_loader.sv
// +-------------------------------------------------------------------------+
// | code_loader : boot-time byte-stream writer for the 32-bit code memory;   |
// | holds the core in reset until a load completes.                          |
// | Optional checksum byte: define CODE_LOADER_CHECKSUM_EN.                  |
// | Revision 1.0                                                             |
// +-------------------------------------------------------------------------+
`default_nettype none

module code_loader #(
  parameter int CODE_DIR_WIDTH = 4,
  parameter int CODE_DEPTH     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  code_loader_if.slave bus,
  output logic         cpu_rst_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  localparam int CNT_W = $clog2(CODE_DEPTH + 1);
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(CODE_DEPTH);
  localparam logic [CNT_W-1:0] c_ONE_CNT   = CNT_W'(1);

`ifdef CODE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_CHK   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t                    state_q;
  logic [CNT_W-1:0]          nwords_q;
  logic [CNT_W-1:0]          idx_q;
  logic [1:0]                bidx_q;
  logic [23:0]               asm_q;
  logic                      byte_ready_q;
  logic                      mem_we_q;
  logic [CODE_DIR_WIDTH-1:0] mem_addr_q;
  logic [31:0]               mem_wdata_q;
  logic                      cpu_rst_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      xfer;
  logic [31:0]               word_d;
  logic [CNT_W-1:0]          nwords_d;
  logic [CNT_W-1:0]          idx_d;

  assign xfer   = bus.byte_valid && byte_ready_q;
  // Only the three older bytes are kept; the fourth completes the word directly.
  assign word_d = {asm_q, bus.byte_data};
  assign idx_d  = idx_q + c_ONE_CNT;
  assign nwords_d = ((bus.byte_data == 8'd0) || (int'(bus.byte_data) > CODE_DEPTH))
                    ? c_DEPTH_CNT : CNT_W'(bus.byte_data);

`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic       err_q;
  assign sum_d = sum_q + bus.byte_data;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      nwords_q     <= '0;
      idx_q        <= '0;
      bidx_q       <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q      <= S_HDR;
            idx_q        <= '0;
            bidx_q       <= '0;
            mem_addr_q   <= '0;
            byte_ready_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
          end
        end

        S_HDR: begin
          if (xfer) begin
            nwords_q <= nwords_d;
            state_q  <= S_LOAD;
`ifdef CODE_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
          end
        end

        S_LOAD: begin
          if (xfer) begin
            asm_q  <= word_d[23:0];
            bidx_q <= bidx_q + 2'd1;
`ifdef CODE_LOADER_CHECKSUM_EN
            sum_q  <= sum_d;
`endif
            if (bidx_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              mem_we_q     <= 1'b1;
              mem_wdata_q  <= word_d;
              mem_addr_q   <= CODE_DIR_WIDTH'(idx_q);
            end
          end
        end

        S_WRITE: begin
          idx_q <= idx_d;
          if (idx_d == nwords_q) begin
`ifdef CODE_LOADER_CHECKSUM_EN
            state_q      <= S_CHK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
`endif
          end else begin
            state_q      <= S_LOAD;
            byte_ready_q <= 1'b1;
          end
        end

`ifdef CODE_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            // A good stream sums to zero modulo 256, checksum included.
            err_q        <= (sum_d != 8'd0);
          end
        end
`endif

        default: begin
          state_q      <= S_IDLE;
          byte_ready_q <= 1'b0;
          cpu_rst_q    <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_code_loader.sv
// +-------------------------------------------------------------------------+
// | tb_code_loader : directed and randomized loads against a memory model.   |
// | Revision 1.0                                                             |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_code_loader;

  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic cpu_rst_o, busy_o, done_o, err_o;

  code_loader_if #(.CODE_DIR_WIDTH(DW)) bus ();

  code_loader #(.CODE_DIR_WIDTH(DW), .CODE_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .bus       (bus),
    .cpu_rst_o (cpu_rst_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rdy_viol = 0;
  logic [31:0] mem_cap   [DEPTH];
  logic [31:0] model_mem [DEPTH];
  logic [7:0]  dbytes    [4*DEPTH];

  // Observed memory image plus ready-vs-state consistency.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem_cap[bus.mem_addr] = bus.mem_wdata;
      wr_cnt++;
    end
    if (!rst) begin
      if ((busy_o && !bus.mem_we && !bus.byte_ready) ||
          (bus.mem_we && bus.byte_ready) ||
          (!busy_o && bus.byte_ready))
        rdy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},   32'(bus.byte_ready), 32'd0);
    chk({tag, "_we"},      32'(bus.mem_we),     32'd0);
    chk({tag, "_addr"},    32'(bus.mem_addr),   32'd0);
    chk({tag, "_wdata"},   bus.mem_wdata,       32'd0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst_o),      32'd1);
    chk({tag, "_busy"},    32'(busy_o),         32'd0);
    chk({tag, "_done"},    32'(done_o),         32'd0);
    chk({tag, "_err"},     32'(err_o),          32'd0);
  endtask

  // Idle gap cycles first (optionally with a spurious start), then one transfer.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic noise);
    logic ok;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      start_i        = noise;
      tick();
    end
    start_i        = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        ok = 1'b1;
        tick();
      end
    end
    if (!ok) chk("byte_timeout", 32'(ok), 32'd1);
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  task automatic do_load(input string tag, input logic [7:0] hdr, input int gap,
                         input logic noise, input logic use_ovr, input logic [7:0] ovr);
    int n;
    int wr0;
    int rv0;
    logic [7:0]  sum;
    logic [31:0] wexp;
    logic        exp_err;
    n   = (hdr == 8'd0 || int'(hdr) > DEPTH) ? DEPTH : int'(hdr);
    wr0 = wr_cnt;
    rv0 = rdy_viol;
    exp_err = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_start_busy"},    32'(busy_o),         32'd1);
    chk({tag, "_start_ready"},   32'(bus.byte_ready), 32'd1);
    chk({tag, "_start_cpu_rst"}, 32'(cpu_rst_o),      32'd1);
    chk({tag, "_start_done"},    32'(done_o),         32'd0);
    sum = hdr;
    send_byte(hdr, gap, noise);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(dbytes[4*w+k], gap, noise);
        sum = sum + dbytes[4*w+k];
      end
      wexp = (32'(dbytes[4*w]) << 24) + (32'(dbytes[4*w+1]) << 16) +
             (32'(dbytes[4*w+2]) << 8) + 32'(dbytes[4*w+3]);
      chk({tag, "_we"},       32'(bus.mem_we),     32'd1);
      chk({tag, "_addr"},     32'(bus.mem_addr),   32'(w));
      chk({tag, "_wdata"},    bus.mem_wdata,       wexp);
      chk({tag, "_we_ready"}, 32'(bus.byte_ready), 32'd0);
      model_mem[w] = wexp;
    end
`ifdef CODE_LOADER_CHECKSUM_EN
    begin
      logic [7:0] cb;
      cb = use_ovr ? ovr : 8'(8'd0 - sum);
      send_byte(cb, gap, noise);
      sum = sum + cb;
      exp_err = (sum != 8'd0);
    end
`else
    if (use_ovr) sum = sum + ovr;
    tick();
`endif
    chk({tag, "_done"},     32'(done_o),         32'd1);
    chk({tag, "_cpu_rst"},  32'(cpu_rst_o),      32'd0);
    chk({tag, "_busy"},     32'(busy_o),         32'd0);
    chk({tag, "_err"},      32'(err_o),          32'(exp_err));
    chk({tag, "_nwrites"},  32'(wr_cnt - wr0),   32'(n));
    chk({tag, "_ready_ok"}, 32'(rdy_viol - rv0), 32'd0);
  endtask

  initial begin
    int wr0;
    logic [7:0] hdr;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Two-word directed load.
    dbytes[0] = 8'h20; dbytes[1] = 8'h08; dbytes[2] = 8'h00; dbytes[3] = 8'h05;
    dbytes[4] = 8'hAC; dbytes[5] = 8'h01; dbytes[6] = 8'h00; dbytes[7] = 8'h03;
    do_load("two_word", 8'h02, 0, 1'b0, 1'b0, 8'h00);

    // Header clamp: zero and oversize counts both mean a full memory.
    for (int i = 0; i < 4*DEPTH; i++) dbytes[i] = 8'($urandom);
    do_load("clamp0", 8'h00, 0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4*DEPTH; i++) dbytes[i] = 8'($urandom);
    do_load("clamp_big", 8'hC8, 0, 1'b0, 1'b0, 8'h00);

    // Back-pressure with spurious start pulses while busy.
    dbytes[0] = 8'h8C; dbytes[1] = 8'h02; dbytes[2] = 8'h00; dbytes[3] = 8'h00;
    do_load("bp", 8'h01, 3, 1'b1, 1'b0, 8'h00);

    // Reset after two data bytes: no write, back to reset values.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    wr0 = wr_cnt;
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_nowrite", 32'(wr_cnt - wr0), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    dbytes[0] = 8'h12; dbytes[1] = 8'h34; dbytes[2] = 8'h56; dbytes[3] = 8'h78;
    do_load("reload", 8'h01, 0, 1'b0, 1'b0, 8'h00);

    // Randomized loads.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4*DEPTH; i++) dbytes[i] = 8'($urandom);
      hdr = ($urandom_range(0, 2) != 0) ? 8'($urandom_range(1, DEPTH)) : 8'($urandom);
      do_load("rand", hdr, $urandom_range(0, 2), 1'($urandom), 1'b0, 8'h00);
    end

`ifdef CODE_LOADER_CHECKSUM_EN
    dbytes[0] = 8'h00; dbytes[1] = 8'h00; dbytes[2] = 8'h00; dbytes[3] = 8'h01;
    do_load("cksum_good", 8'h01, 0, 1'b0, 1'b1, 8'hFE);
    do_load("cksum_bad",  8'h01, 0, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 4*DEPTH; i++) dbytes[i] = 8'($urandom);
    do_load("cksum_rand_bad", 8'h03, 1, 1'b0, 1'b1, 8'($urandom));
`endif

    // Memory image must match every word the model expects, earlier loads included.
    for (int i = 0; i < DEPTH; i++) chk("mem_image", mem_cap[i], model_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
